// File: rtl/taxi_pkg.sv
// Purpose: shared trip-FSM state codes and default meter counter limits.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package taxi_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 32;

  localparam logic [STATE_W-1:0] ST_VACANT   = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEARING = 3'd1;
  localparam logic [STATE_W-1:0] ST_MOVING   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAITING  = 3'd3;
  localparam logic [STATE_W-1:0] ST_SETTLE   = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAYMENT  = 3'd5;

  // Defaults shared with the rest of the meter blocks (1 kHz clock).
  localparam int DEF_CNT_STOP      = 100;
  localparam int DEF_CNT_WAIT_TICK = 100;
  localparam int DEF_CNT_SETTLE    = 2;
  localparam int DEF_CNT_SHOW      = 100;

  // The "for hire" light is lit while idle and while the last fare is shown.
  function automatic logic is_for_hire(input logic [STATE_W-1:0] st);
    return (st == ST_VACANT) || (st == ST_PAYMENT);
  endfunction

endpackage

// File: rtl/taxi_edge_det.sv
// Purpose: rising-edge detector for a level button input.
// Latency: combinational output, one-cycle history register.
// Backpressure: none; one event per 0->1 transition, held levels are ignored.
module taxi_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // History register; resetting it high keeps a button held through reset silent.
  always_ff @(posedge clk) begin
    if (rst) din_q <= RST_VAL;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/taxi_trip_ctrl.sv
// Purpose: taxi trip sequencer: hire clear, distance gating, wait billing, fare freeze.
// Latency: state/clear respond 1 cycle after a button edge; pulse_gated is a 1-cycle copy.
// Backpressure: none; pulses outside a trip or coinciding with a stop edge are dropped.
module taxi_trip_ctrl
  import taxi_pkg::*;
#(
  parameter int DW            = 32,
  parameter int CNT_STOP      = DEF_CNT_STOP,
  parameter int CNT_WAIT_TICK = DEF_CNT_WAIT_TICK,
  parameter int CNT_SETTLE    = DEF_CNT_SETTLE,
  parameter int CNT_SHOW      = DEF_CNT_SHOW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_req,
  input  logic               stop_req,
  input  logic               distance_pulse_10m,
  input  logic [DW-1:0]      meter_total,
  output logic               meter_clear,
  output logic               pulse_gated,
  output logic               wait_tick,
  output logic               stopping,
  output logic               vacant,
  output logic [DW-1:0]      fare_hold,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] STOP_LIM    = CNT_W'(CNT_STOP);
  localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(CNT_WAIT_TICK - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(CNT_SETTLE - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST   = CNT_W'(CNT_SHOW - 1);

  logic             start_evt;
  logic             stop_evt;
  logic             in_trip;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] phase_cnt;   // shared by SETTLE and PAYMENT, zeroed on entry

  taxi_edge_det #(.RST_VAL(1'b1)) u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_req),
    .rise (start_evt)
  );

  taxi_edge_det #(.RST_VAL(1'b1)) u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (stop_req),
    .rise (stop_evt)
  );

  assign in_trip     = (state == ST_MOVING) || (state == ST_WAITING);
  assign meter_clear = (state == ST_CLEARING);
  assign stopping    = (state == ST_WAITING);
  assign vacant      = is_for_hire(state);

  // Illegal counter limits (zero or negative) are flagged in simulation.
  always_ff @(posedge clk) begin
    assert (CNT_STOP >= 1 && CNT_WAIT_TICK >= 1 && CNT_SETTLE >= 1 && CNT_SHOW >= 1)
      else $error("taxi_trip_ctrl: counter parameters must be >= 1");
  end

  // Trip FSM with its counters; stop edge outranks distance pulse outranks idle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_VACANT;
      pulse_gated <= 1'b0;
      wait_tick   <= 1'b0;
      fare_hold   <= '0;
      idle_cnt    <= '0;
      wait_cnt    <= '0;
      phase_cnt   <= '0;
    end else begin
      pulse_gated <= in_trip & distance_pulse_10m & ~stop_evt;
      wait_tick   <= 1'b0;
      case (state)
        ST_VACANT: begin
          if (start_evt) begin
            state     <= ST_CLEARING;
            fare_hold <= '0;
          end
        end
        ST_CLEARING: begin
          state    <= ST_MOVING;
          idle_cnt <= '0;
          wait_cnt <= '0;
        end
        ST_MOVING: begin
          if (stop_evt) begin
            state     <= ST_SETTLE;
            phase_cnt <= '0;
          end else if (distance_pulse_10m) begin
            idle_cnt <= '0;
          end else if (idle_cnt + 32'd1 >= STOP_LIM) begin
            idle_cnt <= STOP_LIM;
            wait_cnt <= '0;
            state    <= ST_WAITING;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        ST_WAITING: begin
          if (stop_evt) begin
            state     <= ST_SETTLE;
            phase_cnt <= '0;
            wait_cnt  <= '0;
          end else if (distance_pulse_10m) begin
            state    <= ST_MOVING;
            wait_cnt <= '0;
            idle_cnt <= '0;
          end else if (wait_cnt == TICK_LAST) begin
            wait_cnt  <= '0;
            wait_tick <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_SETTLE: begin
          // Give the datapath time to absorb the last forwarded pulse before freezing.
          if (phase_cnt == SETTLE_LAST) begin
            fare_hold <= meter_total;
            phase_cnt <= '0;
            state     <= ST_PAYMENT;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        ST_PAYMENT: begin
          if (start_evt) begin
            state     <= ST_CLEARING;
            fare_hold <= '0;
            phase_cnt <= '0;
          end else if (phase_cnt == SHOW_LAST) begin
            state     <= ST_VACANT;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        default: state <= ST_VACANT;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Purpose: directed self-checking bench for the taxi trip controller.
// Latency: checks sample 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_taxi_trip_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_req;
  logic        stop_req;
  logic        distance_pulse_10m;
  logic [31:0] meter_total;
  logic        meter_clear;
  logic        pulse_gated;
  logic        wait_tick;
  logic        stopping;
  logic        vacant;
  logic [31:0] fare_hold;
  logic [2:0]  state;

  int checks = 0;
  int passed = 0;

  taxi_trip_ctrl #(
    .DW(32), .CNT_STOP(4), .CNT_WAIT_TICK(3), .CNT_SETTLE(2), .CNT_SHOW(10)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_req          (start_req),
    .stop_req           (stop_req),
    .distance_pulse_10m (distance_pulse_10m),
    .meter_total        (meter_total),
    .meter_clear        (meter_clear),
    .pulse_gated        (pulse_gated),
    .wait_tick          (wait_tick),
    .stopping           (stopping),
    .vacant             (vacant),
    .fare_hold          (fare_hold),
    .state              (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; distance_pulse_10m = 1'b0;
    meter_total = 32'd214;
    step(); step();
    checks++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else passed++;
    checks++; if (vacant !== 1'b1) $display("FAIL rst_vacant got %0b want 1", vacant); else passed++;
    checks++; if ({meter_clear, pulse_gated, wait_tick, stopping} !== 4'b0)
      $display("FAIL rst_outs got %b want 0000", {meter_clear, pulse_gated, wait_tick, stopping}); else passed++;
    checks++; if (fare_hold !== 32'd0) $display("FAIL rst_fare got %0d want 0", fare_hold); else passed++;
    rst = 1'b0;
    step();
    checks++; if (state !== 3'd0) $display("FAIL idle_state got %0d want 0", state); else passed++;
  endtask

  task automatic test_start_clear();
    start_req = 1'b1;
    step();
    checks++; if (state !== 3'd1) $display("FAIL clr_state got %0d want 1", state); else passed++;
    checks++; if (meter_clear !== 1'b1) $display("FAIL clr_pulse got %0b want 1", meter_clear); else passed++;
    checks++; if (vacant !== 1'b0) $display("FAIL clr_vacant got %0b want 0", vacant); else passed++;
    step();
    checks++; if (state !== 3'd2) $display("FAIL clr_to_moving got %0d want 2", state); else passed++;
    checks++; if (meter_clear !== 1'b0) $display("FAIL clr_one_cycle got %0b want 0", meter_clear); else passed++;
    step();
    checks++; if (meter_clear !== 1'b0 || state !== 3'd2)
      $display("FAIL clr_held got clear=%0b state=%0d want clear=0 state=2", meter_clear, state); else passed++;
    start_req = 1'b0;
  endtask

  task automatic test_moving_pulses();
    for (int k = 0; k < 3; k++) begin
      distance_pulse_10m = 1'b1;
      step();
      checks++; if (pulse_gated !== 1'b1 || state !== 3'd2 || stopping !== 1'b0)
        $display("FAIL mov_pulse%0d got pg=%0b st=%0d stp=%0b want 1/2/0", k, pulse_gated, state, stopping); else passed++;
      distance_pulse_10m = 1'b0;
      step();
      checks++; if (pulse_gated !== 1'b0 || state !== 3'd2)
        $display("FAIL mov_gap%0d got pg=%0b st=%0d want 0/2", k, pulse_gated, state); else passed++;
    end
    step(); step();
    checks++; if (state !== 3'd2) $display("FAIL idle3_state got %0d want 2", state); else passed++;
    step();
    checks++; if (state !== 3'd3 || stopping !== 1'b1)
      $display("FAIL idle4_wait got st=%0d stp=%0b want 3/1", state, stopping); else passed++;
    for (int p = 0; p < 2; p++) begin
      step();
      checks++; if (wait_tick !== 1'b0) $display("FAIL tick_p%0d_a got %0b want 0", p, wait_tick); else passed++;
      step();
      checks++; if (wait_tick !== 1'b0) $display("FAIL tick_p%0d_b got %0b want 0", p, wait_tick); else passed++;
      step();
      checks++; if (wait_tick !== 1'b1 || state !== 3'd3)
        $display("FAIL tick_p%0d_c got tick=%0b st=%0d want 1/3", p, wait_tick, state); else passed++;
    end
  endtask

  task automatic test_wait_resume();
    step();
    distance_pulse_10m = 1'b1;
    step();
    checks++; if (state !== 3'd2) $display("FAIL resume_state got %0d want 2", state); else passed++;
    checks++; if (pulse_gated !== 1'b1) $display("FAIL resume_pg got %0b want 1", pulse_gated); else passed++;
    checks++; if (wait_tick !== 1'b0 || stopping !== 1'b0)
      $display("FAIL resume_tick got tick=%0b stp=%0b want 0/0", wait_tick, stopping); else passed++;
    distance_pulse_10m = 1'b0;
    step(); step(); step();
    checks++; if (state !== 3'd2) $display("FAIL resume_idle got %0d want 2", state); else passed++;
    step();
    checks++; if (state !== 3'd3) $display("FAIL rewait_state got %0d want 3", state); else passed++;
    step(); step();
    checks++; if (wait_tick !== 1'b0) $display("FAIL rewait_early got %0b want 0", wait_tick); else passed++;
    step();
    checks++; if (wait_tick !== 1'b1) $display("FAIL rewait_tick got %0b want 1", wait_tick); else passed++;
  endtask

  task automatic test_stop_settle_pay();
    stop_req = 1'b1; distance_pulse_10m = 1'b1;
    step();
    checks++; if (state !== 3'd4) $display("FAIL stop_state got %0d want 4", state); else passed++;
    checks++; if (pulse_gated !== 1'b0) $display("FAIL stop_drop got %0b want 0", pulse_gated); else passed++;
    distance_pulse_10m = 1'b0;
    step();
    checks++; if (state !== 3'd4 || pulse_gated !== 1'b0 || wait_tick !== 1'b0)
      $display("FAIL settle2 got st=%0d pg=%0b tick=%0b want 4/0/0", state, pulse_gated, wait_tick); else passed++;
    step();
    checks++; if (state !== 3'd5) $display("FAIL pay_state got %0d want 5", state); else passed++;
    checks++; if (fare_hold !== 32'd214) $display("FAIL pay_fare got %0d want 214", fare_hold); else passed++;
    checks++; if (vacant !== 1'b1) $display("FAIL pay_vacant got %0b want 1", vacant); else passed++;
    stop_req = 1'b0;
    meter_total = 32'd999;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) stop_req = 1'b1;
      step();
      checks++; if (state !== 3'd5 || fare_hold !== 32'd214)
        $display("FAIL pay_hold%0d got st=%0d fare=%0d want 5/214", i, state, fare_hold); else passed++;
    end
    stop_req = 1'b0;
    step();
    checks++; if (state !== 3'd0) $display("FAIL show_end got %0d want 0", state); else passed++;
    checks++; if (fare_hold !== 32'd214) $display("FAIL show_keep got %0d want 214", fare_hold); else passed++;
  endtask

  task automatic test_rehire();
    meter_total = 32'd77;
    start_req = 1'b1; step();
    start_req = 1'b0; step();
    stop_req = 1'b1; step();
    stop_req = 1'b0; step(); step();
    checks++; if (state !== 3'd5 || fare_hold !== 32'd77)
      $display("FAIL trip2_pay got st=%0d fare=%0d want 5/77", state, fare_hold); else passed++;
    step(); step();
    start_req = 1'b1;
    step();
    checks++; if (state !== 3'd1) $display("FAIL rehire_state got %0d want 1", state); else passed++;
    checks++; if (fare_hold !== 32'd0) $display("FAIL rehire_fare got %0d want 0", fare_hold); else passed++;
    checks++; if (meter_clear !== 1'b1) $display("FAIL rehire_clear got %0b want 1", meter_clear); else passed++;
    step();
    checks++; if (state !== 3'd2 || meter_clear !== 1'b0)
      $display("FAIL rehire_move got st=%0d clr=%0b want 2/0", state, meter_clear); else passed++;
  endtask

  task automatic test_reset_mid_trip();
    step(); step(); step(); step();
    checks++; if (state !== 3'd3) $display("FAIL mid_wait got %0d want 3", state); else passed++;
    step();
    rst = 1'b1;
    step();
    checks++; if (state !== 3'd0 || vacant !== 1'b1)
      $display("FAIL mid_rst got st=%0d vac=%0b want 0/1", state, vacant); else passed++;
    checks++; if ({meter_clear, pulse_gated, wait_tick, stopping} !== 4'b0)
      $display("FAIL mid_rst_outs got %b want 0000", {meter_clear, pulse_gated, wait_tick, stopping}); else passed++;
    checks++; if (fare_hold !== 32'd0) $display("FAIL mid_rst_fare got %0d want 0", fare_hold); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (state !== 3'd0 || meter_clear !== 1'b0)
        $display("FAIL held_start%0d got st=%0d clr=%0b want 0/0", i, state, meter_clear); else passed++;
    end
    start_req = 1'b0; step();
    start_req = 1'b1; step();
    checks++; if (state !== 3'd1) $display("FAIL post_rst_hire got %0d want 1", state); else passed++;
    start_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_clear();
    test_moving_pulses();
    test_wait_resume();
    test_stop_settle_pay();
    test_rehire();
    test_reset_mid_trip();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/taxi_trip_ctrl.md
Name: taxi_trip_ctrl

Overview:
Trip-sequencing controller for the taxi meter. It turns driver start/stop requests and the 10 m distance pulse into meter control: a one-cycle clear at hire, gated distance pulses, moving/waiting classification with periodic wait ticks, and a frozen fare at trip end. It sits between the driver buttons/odometer and the fare datapath, which consumes `meter_clear`, `pulse_gated` and `wait_tick` and returns its running total.

Parameters:
- DW, 32, width of the fare bus.
- CNT_STOP, 100, consecutive cycles with no distance pulse before the taxi counts as stopped (≥1).
- CNT_WAIT_TICK, 100, cycles in WAITING per `wait_tick` pulse (≥1).
- CNT_SETTLE, 2, cycles allowed for the datapath to absorb in-flight pulses before the fare is latched (≥1).
- CNT_SHOW, 100, cycles the fare stays in PAYMENT before returning to VACANT (≥1).

Ports:
- clk  in  1  system clock (1 kHz in the product).
- rst  in  1  reset; synchronous, active-high.
- start_req  in  1  driver "hire" button; level input, edge-detected internally.
- stop_req  in  1  driver "end trip" button; level input, edge-detected internally.
- distance_pulse_10m  in  1  single-cycle pulse per 10 m travelled, synchronous to clk.
- meter_total  in  DW  running fare from the datapath.
- meter_clear  out  1  one-cycle clear pulse to the datapath.
- pulse_gated  out  1  distance pulse forwarded to the datapath.
- wait_tick  out  1  one-cycle waiting-time billing pulse.
- stopping  out  1  high while in WAITING.
- vacant  out  1  "for hire" light.
- fare_hold  out  DW  fare frozen at trip end.
- state  out  3  current FSM state, for display and debug.

Behaviour:
- Reset values, also applied when reset is asserted mid-trip:
  - state=VACANT, vacant=1.
  - meter_clear, pulse_gated, wait_tick and stopping are 0.
  - fare_hold=0; all counters are 0.
  - Edge-detector history registers reset to 1, so a button held through reset does not fire.
- Edge detect: a request fires on a rising edge, i.e. the input is 1 this cycle and was 0 the previous cycle. Holding a button produces one event only.
- State encoding: VACANT=0, CLEARING=1, MOVING=2, WAITING=3, SETTLE=4, PAYMENT=5. Codes 6 and 7 go to VACANT on the next cycle.
- VACANT: a start edge moves to CLEARING. Stop edges and distance pulses are ignored.
- CLEARING: lasts exactly 1 cycle.
  - meter_clear=1 during this cycle and fare_hold is cleared to 0.
  - Moves unconditionally to MOVING; the idle counter starts at 0.
- MOVING:
  - The idle counter resets to 0 on each distance pulse and otherwise increments, saturating at CNT_STOP.
  - When the idle counter would reach CNT_STOP, go to WAITING.
  - A stop edge goes to SETTLE.
- WAITING:
  - stopping=1.
  - The wait counter increments each cycle. At the value CNT_WAIT_TICK-1 it asserts wait_tick the next cycle and wraps to 0.
  - A distance pulse returns the FSM to MOVING and is forwarded. The partial wait count is discarded and the idle counter is zeroed.
  - A stop edge goes to SETTLE.
- pulse_gated: registered copy of distance_pulse_10m, so it has 1-cycle latency. It is forwarded only when the pulse arrives in MOVING or WAITING and no stop edge occurs in the same cycle. Otherwise the pulse is dropped.
- Priority in a single cycle: rst > stop edge > distance pulse > idle timeout.
- SETTLE: lasts CNT_SETTLE cycles, with no forwarding and no ticks. On exit, fare_hold <= meter_total and the FSM moves to PAYMENT.
- PAYMENT:
  - fare_hold is held.
  - After CNT_SHOW cycles, go to VACANT; fare_hold is retained until the next CLEARING.
  - A start edge during PAYMENT goes directly to CLEARING (immediate re-hire).
  - Stop edges are ignored.
- vacant is 1 in VACANT and PAYMENT, 0 otherwise.
- Counters are 32-bit unsigned. Parameters below 1 are illegal; simulation asserts on them.

Decomposition:
- Shared package taxi_pkg holds:
  - the state localparams and the 3-bit state width;
  - the default counter constants, shared with the existing meter blocks.
- One natural sub-module, taxi_edge_det: a rising-edge detector instantiated twice, with a parameterised history reset value (1 here).

Test Plan:
Overrides for all scenarios: CNT_STOP=4, CNT_WAIT_TICK=3, CNT_SETTLE=2, CNT_SHOW=10, DW=32.
1. Reset, then start_req raised at cycle t and held → state=CLEARING and meter_clear=1 at t+1 only; MOVING at t+2; held button gives no second clear.
2. In MOVING, pulses every 2 cycles → pulse_gated copies each pulse one cycle later and stopping stays 0. Then no pulses → WAITING entered after 4 idle cycles, and wait_tick fires every 3 cycles.
3. In WAITING with wait counter=1, a distance pulse arrives → state=MOVING next cycle, pulse_gated=1, no wait_tick; a later wait period restarts its count from 0.
4. Stop edge coinciding with a distance pulse → pulse dropped (pulse_gated stays 0); 2 SETTLE cycles; with meter_total=32'd214, fare_hold=214 in PAYMENT; VACANT after 10 cycles with fare_hold still 214.
5. Start edge in PAYMENT cycle 3 → CLEARING next cycle, fare_hold=0, meter_clear pulse issued.
6. rst asserted in WAITING mid-tick-count → next cycle state=VACANT, all outputs at reset values, and a start_req held high across reset does not start a trip.
